// File: rtl/insn_fetch.sv
// insn_fetch: instruction fetch front-end.
//
// Issues one fetch per cycle to a memory whose read data comes back one cycle
// later. Returned words are queued with their PC and exception flag in a small
// FIFO, which decode drains through a valid/ready handshake. Branch, jump and
// trap logic can redirect the fetch PC at any time.
//
// Parameters:
//   RESET_PC - first fetch address after reset
//   DEPTH    - FIFO entries (>= 2)
//
// Ports:
//   i_clk, i_rst_n     - clock, synchronous active-low reset
//   o_imem_pc          - fetch address (equals the pc register)
//   i_imem_insn        - read data for the previous cycle's o_imem_pc
//   i_imem_exception   - misalignment flag for the current o_imem_pc
//   o_valid / i_ready  - head-of-FIFO handshake towards decode
//   o_insn, o_pc       - head instruction and its PC
//   o_exception        - head entry carries a fetch exception
//   i_redirect_valid   - redirect request
//   i_redirect_pc      - redirect target
module insn_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [31:0] o_imem_pc,
  input  logic [31:0] i_imem_insn,
  input  logic        i_imem_exception,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_insn,
  output logic [31:0] o_pc,
  output logic        o_exception,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc
);

  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {RUN, HALT} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc, pc_nxt;
  logic               inflight;
  logic [31:0]        infl_pc;
  logic               infl_exc;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [31:0]        fifo_insn [DEPTH];
  logic [31:0]        fifo_pc   [DEPTH];
  logic               fifo_exc  [DEPTH];

  logic               pop, enq, issue;
  logic [CNT_W:0]     occupancy, limit;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue decision and next-state logic. The occupancy test is written as
  // count + inflight < DEPTH + pop so it never goes negative.
  always_comb begin
    pop       = o_valid & i_ready;
    enq       = inflight & ~i_redirect_valid;
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    limit     = (CNT_W + 1)'(DEPTH) + {{CNT_W{1'b0}}, pop};
    issue     = (state == RUN) & ~i_redirect_valid & (occupancy < limit);
    state_nxt = state;
    pc_nxt    = pc;
    if (i_redirect_valid) begin
      state_nxt = RUN;
      pc_nxt    = i_redirect_pc;
    end else if (issue) begin
      // A misaligned fetch is issued once, then fetch parks until redirected.
      if (i_imem_exception) state_nxt = HALT;
      else                  pc_nxt    = pc + 32'd4;
    end
  end

  // State and PC registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= RUN;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // In-flight tracking. Skipping issue in a redirect cycle is what squashes
  // the response that would otherwise be enqueued in the following cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      inflight <= 1'b0;
      infl_pc  <= '0;
      infl_exc <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_pc  <= pc;
        infl_exc <= i_imem_exception;
      end
    end
  end

  // FIFO storage; an exception entry carries a NOP instead of memory data.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && enq) begin
      fifo_pc[wr_ptr]   <= infl_pc;
      fifo_insn[wr_ptr] <= infl_exc ? NOP : i_imem_insn;
      fifo_exc[wr_ptr]  <= infl_exc;
    end
  end

  // FIFO pointers and count. A redirect empties the queue outright.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // The issue rule reserves a slot for every in-flight access.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && enq && !pop) begin
      assert (count < CNT_W'(DEPTH))
        else $error("insn_fetch: enqueue into full FIFO");
    end
  end

  assign o_imem_pc   = pc;
  assign o_valid     = (count != '0);
  assign o_insn      = o_valid ? fifo_insn[rd_ptr] : NOP;
  assign o_pc        = o_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign o_exception = o_valid ? fifo_exc[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_insn_fetch.sv
// tb_insn_fetch: directed, table-driven bench for insn_fetch.
//
// A one-cycle-latency memory model returns a word derived from the address;
// misalignment is flagged combinationally. Each row drives the inputs for one
// cycle just after the rising edge and checks the registered outputs at the
// falling edge of that same cycle.
module tb_insn_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc;
  logic [31:0] imem_insn = 32'h0;
  logic        imem_exception;
  logic        valid;
  logic        ready;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        exception;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_exc;
    logic [31:0] exp_imem;
  } vec_t;

  vec_t vecs[$];

  insn_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_pc        (imem_pc),
    .i_imem_insn      (imem_insn),
    .i_imem_exception (imem_exception),
    .o_valid          (valid),
    .i_ready          (ready),
    .o_insn           (insn),
    .o_pc             (pc),
    .o_exception      (exception),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory contents: 0x00500093, 0x00A00113, 0x00F00193, ... by word index.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'h0050_0093 + (a >> 2) * 32'h0050_0080;
  endfunction

  // Registered read port and combinational misalignment flag.
  always @(posedge clk) imem_insn <= memWord(imem_pc);
  assign imem_exception = (imem_pc[1:0] != 2'b00);

  task automatic compare32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst_n          = r;
    ready          = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // An empty FIFO must present NOP / PC 0 / no exception; an exception entry
  // presents NOP; a normal entry presents the memory word at its PC.
  task automatic checkOutput(input string name, input logic ev, input logic [31:0] epc,
                             input logic eexc, input logic [31:0] eimem);
    logic [31:0] exp_insn;
    @(negedge clk);
    exp_insn = (ev && !eexc) ? memWord(epc) : NOP;
    compare32({name, " valid"},   {31'b0, valid},     {31'b0, ev});
    compare32({name, " pc"},      pc,                 ev ? epc : 32'h0);
    compare32({name, " insn"},    insn,               exp_insn);
    compare32({name, " exc"},     {31'b0, exception}, {31'b0, ev & eexc});
    compare32({name, " imem_pc"}, imem_pc,            eimem);
  endtask

  task automatic addRow(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                        input logic ev, input logic [31:0] epc, input logic [31:0] eimem);
    vecs.push_back('{r, rdy, rv, rpc, ev, epc, 1'b0, eimem});
  endtask

  task automatic step(input string name, input logic r, input logic rdy, input logic rv,
                      input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                      input logic eexc, input logic [31:0] eimem);
    applyStimulus(r, rdy, rv, rpc);
    checkOutput(name, ev, epc, eexc, eimem);
  endtask

  initial begin
    rst_n          = 1'b0;
    ready          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset release with i_ready=1: first valid in cycle 2, back-to-back PCs.
    addRow(1, 1, 0, 0, 0, 32'h0,  32'h0);
    addRow(1, 1, 0, 0, 0, 32'h0,  32'h4);
    addRow(1, 1, 0, 0, 1, 32'h0,  32'h8);
    addRow(1, 1, 0, 0, 1, 32'h4,  32'hC);
    addRow(1, 1, 0, 0, 1, 32'h8,  32'h10);
    addRow(0, 1, 0, 0, 1, 32'hC,  32'h14);
    // Back-pressure: i_ready=0 for 5 cycles after the first valid.
    addRow(1, 0, 0, 0, 0, 32'h0,  32'h0);
    addRow(1, 0, 0, 0, 0, 32'h0,  32'h4);
    for (int i = 0; i < 5; i++) addRow(1, 0, 0, 0, 1, 32'h0, 32'h8);
    addRow(1, 1, 0, 0, 1, 32'h0,  32'h8);
    addRow(1, 1, 0, 0, 1, 32'h4,  32'hC);
    addRow(1, 1, 0, 0, 1, 32'h8,  32'h10);
    // Redirect to 0x100 with one entry buffered and one in flight.
    addRow(1, 1, 1, 32'h100, 1, 32'hC, 32'h14);
    addRow(1, 1, 0, 0, 0, 32'h0,   32'h100);
    addRow(1, 1, 0, 0, 0, 32'h0,   32'h104);
    addRow(1, 1, 0, 0, 1, 32'h100, 32'h108);
    addRow(1, 1, 0, 0, 1, 32'h104, 32'h10C);

    repeat (2) @(posedge clk);
    checkOutput("reset", 0, 32'h0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].ready, vecs[i].redir, vecs[i].redir_pc);
      checkOutput($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                  vecs[i].exp_exc, vecs[i].exp_imem);
    end

    // Misaligned redirect: one exception entry, fetch parks until redirected.
    step("mis0", 1, 1, 1, 32'h102, 1, 32'h108, 0, 32'h110);
    step("mis1", 1, 1, 0, 0,       0, 32'h0,   0, 32'h102);
    step("mis2", 1, 1, 0, 0,       0, 32'h0,   0, 32'h102);
    step("mis3", 1, 1, 0, 0,       1, 32'h102, 1, 32'h102);
    step("mis4", 1, 1, 0, 0,       0, 32'h0,   0, 32'h102);
    step("mis5", 1, 1, 1, 32'h200, 0, 32'h0,   0, 32'h102);
    step("mis6", 1, 1, 0, 0,       0, 32'h0,   0, 32'h200);
    step("mis7", 1, 1, 0, 0,       0, 32'h0,   0, 32'h204);
    step("mis8", 1, 1, 0, 0,       1, 32'h200, 0, 32'h208);
    step("mis9", 1, 1, 0, 0,       1, 32'h204, 0, 32'h20C);

    // PC wrap from 0xFFFF_FFFC to 0.
    step("wrap0", 1, 1, 1, 32'hFFFF_FFFC, 1, 32'h208,       0, 32'h210);
    step("wrap1", 1, 1, 0, 0,             0, 32'h0,         0, 32'hFFFF_FFFC);
    step("wrap2", 1, 1, 0, 0,             0, 32'h0,         0, 32'h0);
    step("wrap3", 1, 1, 0, 0,             1, 32'hFFFF_FFFC, 0, 32'h4);
    step("wrap4", 1, 0, 0, 0,             1, 32'h0,         0, 32'h8);

    // Mid-stream reset with two entries buffered; stale response discarded.
    step("rst0", 1, 0, 0, 0, 1, 32'h0, 0, 32'h8);
    step("rst1", 0, 0, 0, 0, 1, 32'h0, 0, 32'h8);
    step("rst2", 1, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    step("rst3", 1, 1, 0, 0, 0, 32'h0, 0, 32'h4);
    step("rst4", 1, 1, 0, 0, 1, 32'h0, 0, 32'h8);
    step("rst5", 1, 1, 0, 0, 1, 32'h4, 0, 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
